// File: rtl/fetch_stage.sv
// Fetch stage: owns the F-stage PC and the IF/ID register, and issues instruction-memory
// requests over a variable-latency ready handshake. A skid buffer holds a word returned under stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pcD,
    output logic [31:0] instrD,
    output logic        validD,
    output logic        adelD,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {StFetch, StHold, StMisal} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic        valid_d_q, valid_d_d;
    logic        adel_d_q, adel_d_d;
    logic [31:0] skid_q, skid_d;
    logic        advance;
    logic [31:0] word;

    // The F instruction moves into D: this is the only moment pcF advances (delay-slot semantics).
    always_comb begin
        advance = 1'b0;
        word    = 32'h0;
        unique case (state_q)
            StFetch: begin
                advance = imem_ready && !stall;
                word    = imem_rdata;
            end
            StHold: begin
                advance = !stall;
                word    = skid_q;
            end
            StMisal: begin
                advance = !stall;
                word    = 32'h0;
            end
            default: begin
                advance = 1'b0;
                word    = 32'h0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = (next_pc[1:0] != 2'b00) ? StMisal : StFetch;
        end else if (state_q == StFetch && imem_ready && stall) begin
            state_d = StHold;
        end
    end

    // Outputs; imem_req depends only on state and reset_n
    always_comb begin
        imem_req   = reset_n && (state_q == StFetch);
        fetch_busy = reset_n && (state_q == StFetch) && !imem_ready;
        imem_addr  = pc_f_q;
    end

    // Datapath next-state
    always_comb begin
        pc_f_d    = pc_f_q;
        pc_d_d    = pc_d_q;
        instr_d_d = instr_d_q;
        valid_d_d = valid_d_q;
        adel_d_d  = adel_d_q;
        skid_d    = skid_q;

        if (advance) begin
            pc_f_d = next_pc;
        end
        if (state_q == StFetch && imem_ready && stall) begin
            skid_d = imem_rdata;
        end

        if (flush_d) begin
            instr_d_d = 32'h0;
            valid_d_d = 1'b0;
            adel_d_d  = 1'b0;
        end else if (advance) begin
            pc_d_d    = pc_f_q;
            instr_d_d = word;
            valid_d_d = 1'b1;
            adel_d_d  = (state_q == StMisal);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_f_q    <= RESET_PC;
            pc_d_q    <= 32'h0;
            instr_d_q <= 32'h0;
            valid_d_q <= 1'b0;
            adel_d_q  <= 1'b0;
            skid_q    <= 32'h0;
        end else begin
            pc_f_q    <= pc_f_d;
            pc_d_q    <= pc_d_d;
            instr_d_q <= instr_d_d;
            valid_d_q <= valid_d_d;
            adel_d_q  <= adel_d_d;
            skid_q    <= skid_d;
        end
    end

    assign pcF    = pc_f_q;
    assign pcD    = pc_d_q;
    assign instrD = instr_d_q;
    assign validD = valid_d_q;
    assign adelD  = adel_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays memory and next-PC logic with fixed vectors.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic [31:0] next_pc;
    logic        stall;
    logic        flush_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pcF;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic        validD;
    logic        adelD;
    logic        fetch_busy;

    int n_cmp;
    int n_err;

    fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush_d    (flush_d),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pcF        (pcF),
        .pcD        (pcD),
        .instrD     (instrD),
        .validD     (validD),
        .adelD      (adelD),
        .fetch_busy (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1ns later, outputs are checked 1ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        stall      = 1'b0;
        flush_d    = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h0;
        next_pc    = 32'h0;
        tick();
        tick();

        // Reset state
        settle();
        check_eq("rst_pcF", pcF, 32'h3000);
        check_eq("rst_pcD", pcD, 32'h0);
        check_eq("rst_instrD", instrD, 32'h0);
        check_eq("rst_validD", {31'b0, validD}, 32'h0);
        check_eq("rst_adelD", {31'b0, adelD}, 32'h0);
        check_eq("rst_req", {31'b0, imem_req}, 32'h0);
        check_eq("rst_busy", {31'b0, fetch_busy}, 32'h0);

        // First fetch at 0x3000, zero wait
        reset_n    = 1'b1;
        imem_rdata = 32'hA000_0000;
        next_pc    = 32'h3004;
        settle();
        check_eq("f0_req", {31'b0, imem_req}, 32'h1);
        check_eq("f0_addr", imem_addr, 32'h3000);
        check_eq("f0_busy", {31'b0, fetch_busy}, 32'h0);
        tick();
        check_eq("f0_pcD", pcD, 32'h3000);
        check_eq("f0_instrD", instrD, 32'hA000_0000);
        check_eq("f0_validD", {31'b0, validD}, 32'h1);
        check_eq("f1_addr", imem_addr, 32'h3004);

        // Memory wait of 3 cycles at 0x3004
        imem_ready = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        next_pc    = 32'h3008;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("wait_req", {31'b0, imem_req}, 32'h1);
            check_eq("wait_addr", imem_addr, 32'h3004);
            check_eq("wait_busy", {31'b0, fetch_busy}, 32'h1);
            check_eq("wait_pcD", pcD, 32'h3000);
            tick();
        end
        imem_ready = 1'b1;
        imem_rdata = 32'hA000_0001;
        settle();
        check_eq("acc_busy", {31'b0, fetch_busy}, 32'h0);
        tick();
        check_eq("acc_pcD", pcD, 32'h3004);
        check_eq("acc_instrD", instrD, 32'hA000_0001);
        check_eq("f2_addr", imem_addr, 32'h3008);

        // Zero-wait fetch at 0x3008
        imem_rdata = 32'hA000_0002;
        next_pc    = 32'h300C;
        tick();
        check_eq("f2_pcD", pcD, 32'h3008);
        check_eq("f3_pcF", pcF, 32'h300C);

        // Word returned under stall goes to the skid buffer
        stall      = 1'b1;
        imem_rdata = 32'h2408_0001;
        next_pc    = 32'h3010;
        tick();
        imem_rdata = 32'hDEAD_BEEF;
        settle();
        check_eq("hold_req", {31'b0, imem_req}, 32'h0);
        check_eq("hold_busy", {31'b0, fetch_busy}, 32'h0);
        check_eq("hold_pcF", pcF, 32'h300C);
        check_eq("hold_instrD", instrD, 32'hA000_0002);
        tick();
        check_eq("hold2_pcD", pcD, 32'h3008);
        check_eq("hold2_req", {31'b0, imem_req}, 32'h0);
        stall = 1'b0;
        tick();
        check_eq("skid_instrD", instrD, 32'h2408_0001);
        check_eq("skid_pcD", pcD, 32'h300C);
        check_eq("skid_pcF", pcF, 32'h3010);
        check_eq("skid_validD", {31'b0, validD}, 32'h1);
        check_eq("skid_req", {31'b0, imem_req}, 32'h1);

        // Misaligned next_pc
        imem_rdata = 32'hA000_0004;
        next_pc    = 32'h3006;
        tick();
        check_eq("mis_pcF", pcF, 32'h3006);
        check_eq("mis_req", {31'b0, imem_req}, 32'h0);
        check_eq("mis_instrD", instrD, 32'hA000_0004);
        next_pc = 32'h3018;
        tick();
        check_eq("adel_pcD", pcD, 32'h3006);
        check_eq("adel_instrD", instrD, 32'h0);
        check_eq("adel_validD", {31'b0, validD}, 32'h1);
        check_eq("adel_adelD", {31'b0, adelD}, 32'h1);
        check_eq("adel_pcF", pcF, 32'h3018);

        // Flush with stall, no transfer
        stall      = 1'b1;
        flush_d    = 1'b1;
        imem_ready = 1'b0;
        tick();
        check_eq("fl_validD", {31'b0, validD}, 32'h0);
        check_eq("fl_instrD", instrD, 32'h0);
        check_eq("fl_adelD", {31'b0, adelD}, 32'h0);
        check_eq("fl_pcD", pcD, 32'h3006);
        check_eq("fl_pcF", pcF, 32'h3018);

        // Flush with stall while ready: word still lands in the skid buffer
        imem_ready = 1'b1;
        imem_rdata = 32'hB000_0000;
        tick();
        check_eq("fls_req", {31'b0, imem_req}, 32'h0);
        stall   = 1'b0;
        flush_d = 1'b0;
        next_pc = 32'h301C;
        tick();
        check_eq("fls_instrD", instrD, 32'hB000_0000);
        check_eq("fls_pcD", pcD, 32'h3018);
        check_eq("fls_pcF", pcF, 32'h301C);

        // Reset while a request is pending; late ready in the reset cycle is ignored
        imem_ready = 1'b0;
        next_pc    = 32'h3020;
        tick();
        reset_n    = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hC000_0000;
        settle();
        check_eq("rr_req", {31'b0, imem_req}, 32'h0);
        check_eq("rr_busy", {31'b0, fetch_busy}, 32'h0);
        tick();
        check_eq("rr_pcF", pcF, 32'h3000);
        check_eq("rr_validD", {31'b0, validD}, 32'h0);
        check_eq("rr_pcD", pcD, 32'h0);
        reset_n    = 1'b1;
        imem_rdata = 32'hC000_0001;
        next_pc    = 32'h3004;
        settle();
        check_eq("rr_addr", imem_addr, 32'h3000);
        check_eq("rr_req2", {31'b0, imem_req}, 32'h1);
        tick();
        check_eq("rr_instrD", instrD, 32'hC000_0001);
        check_eq("rr_pcD2", pcD, 32'h3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
